// File: rtl/clock_divider_bank_pkg.sv
// rtl/clock_divider_bank_pkg.sv - shared constants and divisor helpers for the divider bank
package clocking_pkg;

   localparam int DIVW_DEFAULT = 4;

   // A divisor of 1 cannot produce a square wave, so it runs as 2; 0 keeps the channel stopped.
   function automatic int unsigned clamp_div(input int unsigned n);
      return (n == 1) ? 2 : n;
   endfunction

   function automatic int unsigned half_div(input int unsigned n);
      return n >> 1;
   endfunction

endpackage

// File: rtl/clock_divider_bank_if.sv
// rtl/clock_divider_bank_if.sv - divisor/soft-reset inputs and per-channel clock/reset outputs
interface clock_divider_bank_if #(
   parameter int NCH  = 4,
   parameter int DIVW = 4
);
   logic [NCH*DIVW-1:0] div_sel;
   logic [NCH-1:0]      soft_rst;
   logic [NCH-1:0]      div_clk;
   logic [NCH-1:0]      div_stb;
   logic [NCH-1:0]      rstb_out;
   logic [NCH-1:0]      active;

   modport master (
      output div_sel, soft_rst,
      input  div_clk, div_stb, rstb_out, active
   );

   modport slave (
      input  div_sel, soft_rst,
      output div_clk, div_stb, rstb_out, active
   );
endinterface

// File: rtl/clock_divider_bank_channel.sv
// rtl/clock_divider_bank_channel.sv - one divided clock with period strobe and staged reset
module clock_divider_channel
   import clocking_pkg::*;
#(
   parameter int DIVW       = DIVW_DEFAULT,
   parameter int RST_STAGES = 3
) (
   input  logic            clk,
   input  logic            resetb,
   input  logic [DIVW-1:0] div_sel,
   input  logic            soft_rst,
   output logic            div_clk,
   output logic            div_stb,
   output logic            rstb_out,
   output logic            active
);

   localparam logic [3:0] RST_INIT = 4'(RST_STAGES);

   logic [DIVW-1:0] cnt;
   logic [DIVW-1:0] act_div;
   logic [DIVW-1:0] sel_eff;
   logic [DIVW-1:0] n_cnt;
   logic [DIVW-1:0] n_act;
   logic [DIVW-1:0] n_half;
   logic [3:0]      rst_cnt;
   logic            boundary;

   // The divisor is only resampled at a boundary, so a period never gets cut short.
   always_comb begin
      sel_eff  = DIVW'(clamp_div(32'(div_sel)));
      boundary = (act_div == '0) || (cnt == act_div - 1'b1);
      n_act    = act_div;
      n_cnt    = cnt + 1'b1;
      if (boundary) begin
         n_act = sel_eff;
         n_cnt = '0;
      end
      n_half = DIVW'(half_div(32'(n_act)));
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         cnt     <= '0;
         act_div <= '0;
         div_clk <= 1'b0;
         div_stb <= 1'b0;
         active  <= 1'b0;
      end else begin
         cnt     <= n_cnt;
         act_div <= n_act;
         div_clk <= (n_act != '0) && (n_cnt < n_half);
         div_stb <= (n_act != '0) && (n_cnt == '0);
         active  <= (n_act != '0);
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         rst_cnt <= RST_INIT;
      end else if (div_stb && (rst_cnt != 4'd0)) begin
         rst_cnt <= rst_cnt - 4'd1;
      end
   end

   assign rstb_out = ~((rst_cnt != 4'd0) | soft_rst);

endmodule

// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - bank of NCH independent clock dividers with staged resets
module clock_divider_bank
   import clocking_pkg::*;
#(
   parameter int NCH        = 4,
   parameter int DIVW       = DIVW_DEFAULT,
   parameter int RST_STAGES = 3
) (
   input logic                 clk,
   input logic                 resetb,
   clock_divider_bank_if.slave bus
);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      clock_divider_channel #(
         .DIVW       (DIVW),
         .RST_STAGES (RST_STAGES)
      ) u_ch (
         .clk      (clk),
         .resetb   (resetb),
         .div_sel  (bus.div_sel[i*DIVW +: DIVW]),
         .soft_rst (bus.soft_rst[i]),
         .div_clk  (bus.div_clk[i]),
         .div_stb  (bus.div_stb[i]),
         .rstb_out (bus.rstb_out[i]),
         .active   (bus.active[i])
      );
   end

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb/tb_clock_divider_bank.sv - directed checks of divide ratios, divisor changes and staged resets
module tb_clock_divider_bank;

   logic clk;
   logic resetb;
   int   n_assert;
   int   n_fail;

   clock_divider_bank_if #(.NCH(4), .DIVW(4)) bus ();

   clock_divider_bank #(
      .NCH        (4),
      .DIVW       (4),
      .RST_STAGES (3)
   ) dut (
      .clk    (clk),
      .resetb (resetb),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int n, input logic [3:0] obs, input logic [3:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s step %0d: observed %b expected %b", tag, n, obs, exp);
      end
   endtask

   // Hand-derived waveforms; n counts edges after resetb release (edge 0 is the first).
   // ch0: /4, soft_rst held over samples 25-26, stopped from edge 32.
   // ch1: /3, then div_sel=1 (runs as /2) from edge 12.
   // ch2: /6, div_sel=2 written at cnt=1, period 2 from edge 6.
   // ch3: stopped, then /5 from edge 12.
   task automatic expect_at(input int n, output logic [3:0] ck, output logic [3:0] st,
                            output logic [3:0] ac, output logic [3:0] rb);
      int m;
      ck[0] = (n <= 31) && (n % 4 < 2);
      st[0] = (n <= 31) && (n % 4 == 0);
      ac[0] = (n <= 31);
      rb[0] = (n >= 9) && (n != 25) && (n != 26);
      ck[1] = (n <= 11) ? (n % 3 == 0) : (n % 2 == 0);
      st[1] = ck[1];
      ac[1] = 1'b1;
      rb[1] = (n >= 7);
      ck[2] = (n < 6) ? (n % 6 < 3) : (n % 2 == 0);
      st[2] = (n < 6) ? (n == 0) : (n % 2 == 0);
      ac[2] = 1'b1;
      rb[2] = (n >= 9);
      m     = n - 12;
      ck[3] = (n >= 12) && (m % 5 < 2);
      st[3] = (n >= 12) && (m % 5 == 0);
      ac[3] = (n >= 12);
      rb[3] = (n >= 23);
   endtask

   task automatic run_seq(input int last);
      logic [3:0] ck, st, ac, rb;
      for (int n = 0; n <= last; n++) begin
         @(posedge clk);
         #1;
         expect_at(n, ck, st, ac, rb);
         chk("div_clk", n, bus.div_clk, ck);
         chk("div_stb", n, bus.div_stb, st);
         chk("active", n, bus.active, ac);
         chk("rstb_out", n, bus.rstb_out, rb);
         if (n == 1) bus.div_sel[8 +: 4] = 4'd2;
         if (n == 11) begin
            bus.div_sel[12 +: 4] = 4'd5;
            bus.div_sel[4 +: 4]  = 4'd1;
         end
         if (n == 24) begin
            bus.soft_rst[0] = 1'b1;
            #1;
            chk("soft_rst_on", n, {3'b000, bus.rstb_out[0]}, 4'b0000);
         end
         if (n == 26) begin
            bus.soft_rst[0] = 1'b0;
            #1;
            chk("soft_rst_off", n, {3'b000, bus.rstb_out[0]}, 4'b0001);
         end
         if (n == 28) bus.div_sel[0 +: 4] = 4'd0;
      end
   endtask

   initial begin
      n_assert     = 0;
      n_fail       = 0;
      resetb       = 1'b0;
      bus.soft_rst = 4'b0000;
      bus.div_sel  = {4'd0, 4'd6, 4'd3, 4'd4};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_clk", -1, bus.div_clk, 4'b0000);
      chk("reset_stb", -1, bus.div_stb, 4'b0000);
      chk("reset_active", -1, bus.active, 4'b0000);
      chk("reset_rstb", -1, bus.rstb_out, 4'b0000);

      @(negedge clk);
      resetb = 1'b1;
      run_seq(35);

      // Reassert mid-period, away from any edge: outputs must clear without a clock.
      #2;
      resetb = 1'b0;
      #1;
      chk("async_clk", 99, bus.div_clk, 4'b0000);
      chk("async_stb", 99, bus.div_stb, 4'b0000);
      chk("async_active", 99, bus.active, 4'b0000);
      chk("async_rstb", 99, bus.rstb_out, 4'b0000);

      bus.div_sel = {4'd0, 4'd6, 4'd3, 4'd4};
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetb = 1'b1;
      run_seq(11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
